key_scan_arb: RTL and testbench

Time-shares a single debounce counter across `NUM_KEYS` raw push-button inputs for the logic analyzer front panel, replacing one debounce instance per key. It synchronizes every key, round-robin selects one key whose level disagrees with its debounced state, and qualifies that change over `CNT_MAX+1` stable cycles. It publishes debounced levels and one-cycle press pulses to the analyzer control logic for run/stop, trigger mode and rate select.

---
 rtl/key_scan_arb.sv | 144 ++++++++++++++
 tb/tb_key_scan_arb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_arb.sv
// key_scan_arb: one shared debounce counter qualifies level changes on NUM_KEYS active-low keys, round-robin.
// Latency: LOCK entered 2 edges after a new level is first sampled; commit/flag CNT_MAX+1 edges after entry.
// Backpressure: none; keys that changed wait in SCAN order and keep their change until their level reverts.
// Build option: define KEY_RELEASE_FLAG_EN to add key_rel_flag (one-cycle pulse per qualified release).
module key_scan_arb #(
  parameter int NUM_KEYS = 4,
  parameter int CNT_MAX  = 999_999
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_flag,
  output logic [NUM_KEYS-1:0] key_state,
`ifdef KEY_RELEASE_FLAG_EN
  output logic [NUM_KEYS-1:0] key_rel_flag,
`endif
  output logic                busy
);

  // Index and counter widths; both kept at least one bit wide for degenerate parameters.
  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

  typedef enum logic {
    SCAN = 1'b0,
    LOCK = 1'b1
  } state_t;

  logic [NUM_KEYS-1:0] key_meta;
  logic [NUM_KEYS-1:0] key_sync;
  state_t              state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;

  logic [NUM_KEYS-1:0] cand;
  logic                cand_vld;
  logic [IW-1:0]       cand_idx;
  logic [IW-1:0]       idx_next;
  logic                lock_bounce;
  logic                lock_done;

  // Add an offset to a key index, wrapping modulo NUM_KEYS (works for non power-of-two counts).
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_KEYS) begin
      sum = sum - NUM_KEYS;
    end
    return IW'(sum);
  endfunction

  // Two-flop synchronizer per key; idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      key_meta <= key_in;
      key_sync <= key_meta;
    end
  end

  // A key is pending whenever its synchronized level disagrees with its debounced level.
  assign cand        = key_sync ^ key_state;
  assign idx_next    = wrap_add(idx, 1);
  assign lock_bounce = (key_sync[idx] == key_state[idx]);
  assign lock_done   = (cnt == CNT_LAST);

  // Pick the first pending key at or after rr_ptr, wrapping around the key vector.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = rr_ptr;
    for (int off = 0; off < NUM_KEYS; off++) begin
      if (!cand_vld && cand[wrap_add(rr_ptr, off)]) begin
        cand_vld = 1'b1;
        cand_idx = wrap_add(rr_ptr, off);
      end
    end
  end

  // SCAN/LOCK arbiter: owns the shared counter, debounced levels, pointer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SCAN;
      rr_ptr       <= '0;
      idx          <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      key_state    <= '1;
      key_flag     <= '0;
`ifdef KEY_RELEASE_FLAG_EN
      key_rel_flag <= '0;
`endif
    end else begin
      // Flags are single-cycle pulses; only a commit below raises one bit.
      key_flag     <= '0;
`ifdef KEY_RELEASE_FLAG_EN
      key_rel_flag <= '0;
`endif
      case (state)
        SCAN: begin
          if (cand_vld) begin
            idx   <= cand_idx;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (lock_bounce) begin
            // Level went back before the window closed: drop it and move on fairly.
            rr_ptr <= idx_next;
            busy   <= 1'b0;
            state  <= SCAN;
          end else if (lock_done) begin
            // Stable for the full window: flip the debounced level and report the edge.
            key_state[idx] <= ~key_state[idx];
            if (key_state[idx]) begin
              key_flag[idx] <= 1'b1;
            end
`ifdef KEY_RELEASE_FLAG_EN
            else begin
              key_rel_flag[idx] <= 1'b1;
            end
`endif
            rr_ptr <= idx_next;
            cnt    <= '0;
            busy   <= 1'b0;
            state  <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_arb.sv
// tb_key_scan_arb: directed scenarios with spec latencies plus a random run against a timestamp-based model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_key_scan_arb;

  localparam int NK = 4;
  localparam int CM = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_flag;
  logic [NK-1:0] key_state;
  logic          busy;
`ifdef KEY_RELEASE_FLAG_EN
  logic [NK-1:0] key_rel_flag;
`endif

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  // Reference model: pipeline of sampled levels, debounced levels, and the lock described by
  // which key it holds and the cycle it started, so commit is a timestamp difference.
  logic [NK-1:0] m_sync1;
  logic [NK-1:0] m_sync;
  logic [NK-1:0] m_state;
  logic [NK-1:0] m_flag;
  logic [NK-1:0] m_rel;
  int            m_ptr;
  int            m_lock;
  int            m_start;

  always #5 clk = ~clk;

  key_scan_arb #(.NUM_KEYS(NK), .CNT_MAX(CM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_flag    (key_flag),
    .key_state   (key_state),
`ifdef KEY_RELEASE_FLAG_EN
    .key_rel_flag(key_rel_flag),
`endif
    .busy        (busy)
  );

  task automatic model_reset();
    m_sync1 = '1;
    m_sync  = '1;
    m_state = '1;
    m_flag  = '0;
    m_rel   = '0;
    m_ptr   = 0;
    m_lock  = -1;
    m_start = 0;
  endtask

  task automatic model_update();
    logic [NK-1:0] s1_new;
    logic [NK-1:0] s_new;
    s1_new = key_in;
    s_new  = m_sync1;
    m_flag = '0;
    m_rel  = '0;
    if (m_lock < 0) begin
      for (int off = 0; off < NK; off++) begin
        int j = (m_ptr + off) % NK;
        if (m_lock < 0 && m_sync[j] != m_state[j]) begin
          m_lock  = j;
          m_start = cyc;
        end
      end
    end else if (m_sync[m_lock] == m_state[m_lock]) begin
      m_ptr  = (m_lock + 1) % NK;
      m_lock = -1;
    end else if (cyc - m_start == CM + 1) begin
      m_state[m_lock] = ~m_state[m_lock];
      if (m_state[m_lock] == 1'b0) m_flag[m_lock] = 1'b1;
      else                         m_rel[m_lock]  = 1'b1;
      m_ptr  = (m_lock + 1) % NK;
      m_lock = -1;
    end
    m_sync  = s_new;
    m_sync1 = s1_new;
  endtask

  // Advance one edge, step the model with what the DUT sampled, then settle past the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else        model_update();
    #1;
  endtask

  task automatic test_reset();
    int seen = 0;
    rst_n  = 1'b0;
    key_in = '1;
    model_reset();
    repeat (3) tick();
    nvec++;
    if (key_flag !== 4'h0) begin nfail++; $display("FAIL reset_key_flag got %b want 0000", key_flag); end
    nvec++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++;
    if (key_state !== 4'hF) begin nfail++; $display("FAIL reset_key_state got %h want f", key_state); end
`ifdef KEY_RELEASE_FLAG_EN
    nvec++;
    if (key_rel_flag !== 4'h0) begin nfail++; $display("FAIL reset_rel_flag got %b want 0000", key_rel_flag); end
`endif
    rst_n = 1'b1;
    repeat (100) begin
      tick();
      if (key_flag !== 4'h0 || busy !== 1'b0) seen++;
    end
    nvec++;
    if (seen != 0) begin nfail++; $display("FAIL idle_after_reset got %0d active cycles want 0", seen); end
  endtask

  task automatic test_press_bounce();
    int e0;
    int first = -1;
    int pulses = 0;
    key_in[0] = 1'b0; tick();
    key_in[0] = 1'b1; tick();
    key_in[0] = 1'b0; tick();
    key_in[0] = 1'b1; tick();
    key_in[0] = 1'b0;
    e0 = cyc + 1;
    repeat (45) begin
      tick();
      if (key_flag !== 4'h0) begin
        pulses++;
        if (first < 0) first = cyc;
        nvec++;
        if (key_flag !== 4'b0001) begin nfail++; $display("FAIL press_flag_value got %b want 0001", key_flag); end
      end
    end
    nvec++;
    if (pulses != 1) begin nfail++; $display("FAIL press_pulse_count got %0d want 1", pulses); end
    nvec++;
    if (first - e0 != CM + 3) begin nfail++; $display("FAIL press_latency got %0d want %0d", first - e0, CM + 3); end
    nvec++;
    if (key_state !== 4'hE) begin nfail++; $display("FAIL press_key_state got %h want e", key_state); end
  endtask

  task automatic test_release_bounce();
    int e0;
    int kf = 0;
    int rel = 0;
    int rel_first = -1;
    key_in[0] = 1'b1; tick();
    key_in[0] = 1'b0; tick();
    key_in[0] = 1'b1; tick();
    key_in[0] = 1'b0; tick();
    key_in[0] = 1'b1;
    e0 = cyc + 1;
    repeat (45) begin
      tick();
      if (key_flag !== 4'h0) kf++;
`ifdef KEY_RELEASE_FLAG_EN
      if (key_rel_flag !== 4'h0) begin
        rel++;
        if (rel_first < 0) rel_first = cyc;
        nvec++;
        if (key_rel_flag !== 4'b0001) begin nfail++; $display("FAIL release_rel_value got %b want 0001", key_rel_flag); end
      end
`endif
    end
    nvec++;
    if (kf != 0) begin nfail++; $display("FAIL release_key_flag got %0d pulses want 0", kf); end
    nvec++;
    if (key_state !== 4'hF) begin nfail++; $display("FAIL release_key_state got %h want f", key_state); end
`ifdef KEY_RELEASE_FLAG_EN
    nvec++;
    if (rel != 1) begin nfail++; $display("FAIL release_rel_count got %0d want 1", rel); end
    nvec++;
    if (rel_first - e0 != CM + 3) begin nfail++; $display("FAIL release_rel_latency got %0d want %0d", rel_first - e0, CM + 3); end
`else
    if (rel != 0 || rel_first != -1) $display("unexpected release bookkeeping");
`endif
  endtask

  task automatic test_simultaneous();
    int e0;
    int t1 = -1;
    int t3 = -1;
    int other = 0;
    int settle = -1;
    key_in = 4'b0101;
    e0 = cyc + 1;
    repeat (80) begin
      tick();
      if (key_flag === 4'b0010 && t1 < 0) t1 = cyc;
      else if (key_flag === 4'b1000 && t3 < 0) t3 = cyc;
      else if (key_flag !== 4'h0) other++;
    end
    nvec++;
    if (t1 - e0 != CM + 3) begin nfail++; $display("FAIL simul_first_latency got %0d want %0d", t1 - e0, CM + 3); end
    nvec++;
    if (t1 < 0 || t3 - t1 != CM + 2) begin nfail++; $display("FAIL simul_gap got %0d want %0d", t3 - t1, CM + 2); end
    nvec++;
    if (other != 0) begin nfail++; $display("FAIL simul_extra_flags got %0d want 0", other); end
    nvec++;
    if (key_state !== 4'b0101) begin nfail++; $display("FAIL simul_key_state got %b want 0101", key_state); end
    key_in = '1;
    for (int i = 0; i < 200 && settle < 0; i++) begin
      tick();
      if (key_state === 4'hF && busy === 1'b0) settle = i;
    end
    nvec++;
    if (settle < 0) begin nfail++; $display("FAIL simul_release_timeout got %h want f", key_state); end
  endtask

  task automatic test_glitch();
    int eg;
    int drop = -1;
    int flags = 0;
    key_in[2] = 1'b0;
    repeat (10) tick();
    nvec++;
    if (busy !== 1'b1) begin nfail++; $display("FAIL glitch_busy_high got %b want 1", busy); end
    key_in[2] = 1'b1;
    eg = cyc + 1;
    repeat (40) begin
      tick();
      if (busy === 1'b0 && drop < 0) drop = cyc;
      if (key_flag !== 4'h0) flags++;
    end
    nvec++;
    if (drop < 0 || drop - eg > 3) begin nfail++; $display("FAIL glitch_busy_drop got %0d want <=3", drop - eg); end
    nvec++;
    if (flags != 0) begin nfail++; $display("FAIL glitch_flags got %0d want 0", flags); end
    nvec++;
    if (key_state !== 4'hF) begin nfail++; $display("FAIL glitch_key_state got %h want f", key_state); end
  endtask

  task automatic test_reset_mid_lock();
    int e0;
    int first = -1;
    int pulses = 0;
    int rflags = 0;
    int settle = -1;
    key_in[0] = 1'b0;
    repeat (10) tick();
    nvec++;
    if (busy !== 1'b1) begin nfail++; $display("FAIL midlock_busy got %b want 1", busy); end
    rst_n = 1'b0;
    model_reset();
    #1;
    nvec++;
    if (key_state !== 4'hF || busy !== 1'b0) begin
      nfail++; $display("FAIL midlock_async_clear got state=%h busy=%b want f/0", key_state, busy);
    end
    repeat (4) begin
      tick();
      if (key_flag !== 4'h0) rflags++;
    end
    nvec++;
    if (rflags != 0) begin nfail++; $display("FAIL midlock_flag_in_reset got %0d want 0", rflags); end
    rst_n = 1'b1;
    e0 = cyc + 1;
    repeat (45) begin
      tick();
      if (key_flag !== 4'h0) begin
        pulses++;
        if (first < 0) first = cyc;
        nvec++;
        if (key_flag !== 4'b0001) begin nfail++; $display("FAIL midlock_flag_value got %b want 0001", key_flag); end
      end
    end
    nvec++;
    if (pulses != 1) begin nfail++; $display("FAIL midlock_pulse_count got %0d want 1", pulses); end
    nvec++;
    if (first - e0 != CM + 3) begin nfail++; $display("FAIL midlock_latency got %0d want %0d", first - e0, CM + 3); end
    key_in = '1;
    for (int i = 0; i < 100 && settle < 0; i++) begin
      tick();
      if (key_state === 4'hF && busy === 1'b0) settle = i;
    end
    nvec++;
    if (settle < 0) begin nfail++; $display("FAIL midlock_release_timeout got %h want f", key_state); end
  endtask

  task automatic test_random();
    int shown = 0;
    int rate;
    for (int c = 0; c < 4000; c++) begin
      rate = ((c / 300) % 2 == 0) ? 12 : 60;
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, rate - 1) == 0) key_in[k] = ~key_in[k];
      end
      tick();
      nvec++;
      if (key_flag !== m_flag || key_state !== m_state || busy !== (m_lock >= 0)) begin
        nfail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle%0d got flag=%b state=%b busy=%b want flag=%b state=%b busy=%b",
                   cyc, key_flag, key_state, busy, m_flag, m_state, (m_lock >= 0));
        end
      end
`ifdef KEY_RELEASE_FLAG_EN
      nvec++;
      if (key_rel_flag !== m_rel) begin
        nfail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_rel_cycle%0d got %b want %b", cyc, key_rel_flag, m_rel);
        end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_press_bounce();
    test_release_bounce();
    test_simultaneous();
    test_glitch();
    test_reset_mid_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
